// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined look-ahead adder/subtractor.
package cla_pkg;

   // Operation select encoding.
   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   // Width of one look-ahead slice.
   localparam int SLICE_W = 4;

   // Status flags that travel with the final result.
   typedef struct packed {
      logic co;   // carry out of MSB (1 = no borrow on subtract)
      logic ov;   // signed overflow
      logic z;    // result is zero
      logic n;    // result MSB
   } flags_t;

endpackage

// File: rtl/cla4_slice.sv
// Combinational 4-bit carry-look-ahead slice. All internal carries come
// straight from generate/propagate terms; only the group carry ripples
// between slices.
module cla4_slice
   import cla_pkg::*;
(
   input  logic [SLICE_W-1:0] a,
   input  logic [SLICE_W-1:0] b,
   input  logic               ci,
   output logic [SLICE_W-1:0] s,
   output logic               c3,   // carry into bit 3
   output logic               co    // carry out of bit 3
);

   logic [SLICE_W-1:0] g;
   logic [SLICE_W-1:0] p;
   logic [SLICE_W:0]   c;

   // Look-ahead carry equations, two-level sum of products per carry.
   always_comb begin
      g    = a & b;
      p    = a ^ b;
      c[0] = ci;
      c[1] = g[0] | (p[0] & ci);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & ci);
      s    = p ^ c[SLICE_W-1:0];
   end

   assign c3 = c[3];
   assign co = c[4];

endmodule

// File: rtl/cla_pipe_addsub.sv
// Skewed pipelined carry-look-ahead adder/subtractor with valid/ready flow
// control. Stage k sums chunk k; lower chunks travel as finished sum bits,
// upper chunks as operand bits. WIDTH must be a multiple of 4*STAGES.
module cla_pipe_addsub
   import cla_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             co,
   output logic             ov,
   output logic             z,
   output logic             n
);

   localparam int CW  = WIDTH / STAGES;   // bits summed per stage
   localparam int NSL = CW / SLICE_W;     // slices per stage

   logic [STAGES-1:0] v_q;                // per-stage valid
   logic [STAGES-1:0] v_in;               // valid arriving at each stage
   logic [STAGES-1:0] en;                 // per-stage load enable
   logic [WIDTH-1:0]  x_q [STAGES];       // partial sums + pending a bits
   logic [WIDTH-1:0]  x_d [STAGES];
   logic [WIDTH-1:0]  y_q [STAGES];       // pending (possibly inverted) b bits
   logic [WIDTH-1:0]  y_d [STAGES];
   logic              c_q [STAGES];       // chunk carry into the next stage
   logic              c_d [STAGES];
   flags_t            flags_q;
   flags_t            flags_d;

   // Enable chain from the output back to the input: a stage may load when
   // it is empty or when the stage after it is loading this cycle.
   always_comb begin
      logic acc;
      // NOTE: every output of a combinational block is assigned on every path
      // (here by the full loop) so no latch is inferred.
      acc = out_ready;
      en  = '0;
      for (int k = STAGES - 1; k >= 0; k--) begin
         acc   = ~v_q[k] | acc;
         en[k] = acc;
      end
   end

   // Valid bit presented to each stage's input.
   always_comb begin
      v_in    = '0;
      v_in[0] = in_valid;
      for (int k = 1; k < STAGES; k++) v_in[k] = v_q[k-1];
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CW{1'b1}}) << (k * CW);

      logic [WIDTH-1:0] xin;
      logic             cin;
      logic [CW-1:0]    sum;
      logic [NSL:0]     gc;
      logic [NSL-1:0]   slice_c3;
      logic             unused_c3;

      // Stage 0 takes the ports (subtract = a + ~b + 1); later stages take
      // the previous stage's registers.
      if (k == 0) begin : g_src
         assign xin    = a;
         assign y_d[k] = (op == OP_SUB) ? ~b : b;
         assign cin    = (op == OP_SUB);
      end else begin : g_src
         assign xin    = x_q[k-1];
         assign y_d[k] = y_q[k-1];
         assign cin    = c_q[k-1];
      end

      // Look-ahead slices for this chunk, group carry rippled between them.
      assign gc[0] = cin;
      for (genvar j = 0; j < NSL; j++) begin : g_slice
         cla4_slice u_slice (
            .a  (xin[k*CW + j*SLICE_W +: SLICE_W]),
            .b  (y_d[k][k*CW + j*SLICE_W +: SLICE_W]),
            .ci (gc[j]),
            .s  (sum[j*SLICE_W +: SLICE_W]),
            .c3 (slice_c3[j]),
            .co (gc[j+1])
         );
      end

      // Only the top slice's internal carry matters, and only in the last stage.
      assign unused_c3 = ^slice_c3;

      // Replace this stage's chunk with its sum; everything else passes through.
      assign x_d[k] = (xin & ~CHUNK_MASK) | (WIDTH'(sum) << (k * CW));
      assign c_d[k] = gc[NSL];

      if (k == STAGES - 1) begin : g_flags
         // Flags from the fully assembled result, registered alongside it.
         always_comb begin
            flags_d.co = gc[NSL];
            flags_d.ov = slice_c3[NSL-1] ^ gc[NSL];
            flags_d.z  = ~|x_d[k];
            flags_d.n  = x_d[k][WIDTH-1];
         end
      end
   end

   // Stage registers: valid advances on every enable, data loads only with a
   // real beat so a stalled or idle output stays stable.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every stage samples pre-edge values
      // of its neighbour; blocking here would let a beat skip a stage.
      if (rst) begin
         v_q     <= '0;
         flags_q <= '0;
         for (int k = 0; k < STAGES; k++) begin
            x_q[k] <= '0;
            y_q[k] <= '0;
            c_q[k] <= 1'b0;
         end
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (en[k]) begin
               v_q[k] <= v_in[k];
               if (v_in[k]) begin
                  x_q[k] <= x_d[k];
                  y_q[k] <= y_d[k];
                  c_q[k] <= c_d[k];
               end
            end
         end
         if (en[STAGES-1] && v_in[STAGES-1]) flags_q <= flags_d;
      end
   end

   assign in_ready  = en[0];
   assign out_valid = v_q[STAGES-1];
   assign s         = x_q[STAGES-1];
   assign co        = flags_q.co;
   assign ov        = flags_q.ov;
   assign z         = flags_q.z;
   assign n         = flags_q.n;

endmodule
